// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   - default widths and timeout for mem_arbiter
//   - FSM state encoding (IDLE=0, GRANT0=1, GRANT1=2, RELEASE=3)
package mem_arb_pkg;

    localparam int unsigned DefDataW   = 256;
    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefTimeout = 1023;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant0  = 2'd1,
        StGrant1  = 2'd2,
        StRelease = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: purely combinational two-way pick.
//   req        in  2  request pair, bit 0 = p0, bit 1 = p1
//   favour_p1  in  1  tie-break: 1 -> p1 wins a tie, 0 -> p0 wins
//   gnt        out 2  one-hot grant (all zero when no request)
module mem_arb_pick (
    input  logic [1:0] req,
    input  logic       favour_p1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = favour_p1 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two requesters (p0 instruction side, p1 data side)
// access to a single data memory. A grant is held until mem_ack_i, followed by
// a one-cycle RELEASE. A saturating wait counter raises a sticky timeout_o.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   pN_enable_i, pN_write_i           request and write qualifier (N = 0, 1)
//   pN_addr_i, pN_data_i              request address / write data
//   pN_data_o, pN_ack_o               read data (always mem_data_i) / acknowledge
//   mem_enable_o, mem_write_o         memory request / write
//   mem_addr_o, mem_data_o            memory address / write data (0 when idle)
//   mem_data_i, mem_ack_i             memory read data / acknowledge
//   timeout_o                         sticky: a grant waited TIMEOUT cycles
//
// Configuration macro MEM_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the
// port not most recently granted; otherwise p1 always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              timeout_o
);

    localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic [1:0]      gnt;
    logic            favour_p1;
    logic            in_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic favour_p1_q;

    // After granting p1 favour p0 on the next tie, and vice versa.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            favour_p1_q <= 1'b1;
        end else if (state_q == StIdle && gnt != 2'b00) begin
            favour_p1_q <= gnt[0];
        end
    end

    assign favour_p1 = favour_p1_q;
`else
    assign favour_p1 = 1'b1;
`endif

    mem_arb_pick u_pick (
        .req       ({p1_enable_i, p0_enable_i}),
        .favour_p1 (favour_p1),
        .gnt       (gnt)
    );

    assign in_grant = (state_q == StGrant0) || (state_q == StGrant1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (gnt[1]) begin
                    state_d = StGrant1;
                end else if (gnt[0]) begin
                    state_d = StGrant0;
                end
            end
            StGrant0, StGrant1: begin
                if (mem_ack_i) begin
                    state_d = StRelease;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Flag goes up at the edge where the count reaches TIMEOUT, so it is
        // visible during grant cycle TIMEOUT+1.
        timeout_d = timeout_q | (in_grant && !mem_ack_i && cnt_d == CntMax);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        p0_ack_o     = 1'b0;
        p1_ack_o     = 1'b0;
        p0_data_o    = mem_data_i;
        p1_data_o    = mem_data_i;
        unique case (state_q)
            StGrant0: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p0_write_i;
                mem_addr_o   = p0_addr_i;
                mem_data_o   = p0_data_i;
                p0_ack_o     = mem_ack_i;
            end
            StGrant1: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
                p1_ack_o     = mem_ack_i;
            end
            default: ;
        endcase
    end

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Each transfer pushes its
// expected acknowledge into a scoreboard queue; a negedge monitor pops and
// compares whenever p0_ack_o or p1_ack_o is seen.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i, mem_addr_o;
    logic [DW-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic          p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o, mem_ack_i, timeout_o;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p0_enable_i  (p0_enable_i),
        .p0_write_i   (p0_write_i),
        .p0_addr_i    (p0_addr_i),
        .p0_data_i    (p0_data_i),
        .p0_data_o    (p0_data_o),
        .p0_ack_o     (p0_ack_o),
        .p1_enable_i  (p1_enable_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_ack_o     (p1_ack_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   acks_seen = 0;
    int   acks_exp = 0;
    bit   mon_en = 1'b0;
    bit   to_sticky = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en && (p0_ack_o || p1_ack_o)) begin
            acks_seen++;
            if (sb.size() == 0) begin
                check("unexpected_ack", {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {62'd0, p1_ack_o, p0_ack_o},
                      (mon_e.port == 1) ? 64'd2 : 64'd1);
                check("ack_mem_addr", 64'(mem_addr_o), 64'(mon_e.addr));
                check("ack_mem_write", 64'(mem_write_o), 64'(mon_e.wr));
                check("ack_mem_wdata", mem_data_o, mon_e.wdata);
                check("ack_p0_rdata", p0_data_o, mon_e.rdata);
                check("ack_p1_rdata", p1_data_o, mon_e.rdata);
            end
        end
    end

    // Issue one transfer from IDLE (called at posedge+1). delay = grant cycle
    // in which mem_ack_i is returned.
    task automatic xfer(input string tag, input bit r0, input bit r1, input int ep,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input bit w0, input bit w1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] rd, input int delay);
        exp_t e;
        p0_enable_i = r0; p0_addr_i = a0; p0_write_i = w0; p0_data_i = d0;
        p1_enable_i = r1; p1_addr_i = a1; p1_write_i = w1; p1_data_i = d1;
        mem_data_i = rd;
        e.port  = ep;
        e.addr  = (ep == 1) ? a1 : a0;
        e.wr    = (ep == 1) ? w1 : w0;
        e.wdata = (ep == 1) ? d1 : d0;
        e.rdata = rd;
        sb.push_back(e);
        acks_exp++;
        tick();
        // Grant must be held even after the requester drops enable.
        p0_enable_i = 1'b0;
        p1_enable_i = 1'b0;
        for (int k = 1; k <= delay; k++) begin
            if (k == delay) mem_ack_i = 1'b1;
            @(negedge clk);
            check({tag, "_mem_enable"}, 64'(mem_enable_o), 64'd1);
            check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(e.addr));
            check({tag, "_timeout"}, 64'(timeout_o), 64'(to_sticky || (k > TO)));
            if (k < delay) begin
                check({tag, "_early_ack"}, {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
            end
            tick();
        end
        mem_ack_i = 1'b0;
        @(negedge clk);
        check({tag, "_release_state"}, 64'(dut.state_q), 64'(StRelease));
        check({tag, "_release_enable"}, 64'(mem_enable_o), 64'd0);
        check({tag, "_release_ack"}, {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
        tick();
        @(negedge clk);
        check({tag, "_idle_state"}, 64'(dut.state_q), 64'(StIdle));
        tick();
        if (delay > TO) to_sticky = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
        mem_data_i = '0; mem_ack_i = 0;
        tick();
        tick();
        @(negedge clk);
        check("rst_state", 64'(dut.state_q), 64'(StIdle));
        check("rst_mem_enable", 64'(mem_enable_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_acks", {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
        tick();
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Tie right after reset: p1 wins; second tie depends on policy.
        xfer("tie1", 1, 1, 1, 32'h100, 32'h200, 0, 0, 64'h0, 64'h0, 64'hA1A1, 2);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        xfer("tie2", 1, 1, 0, 32'h104, 32'h204, 0, 0, 64'h0, 64'h0, 64'hB2B2, 2);
`else
        xfer("tie2", 1, 1, 1, 32'h104, 32'h204, 0, 0, 64'h0, 64'h0, 64'hB2B2, 2);
`endif
        xfer("p1_read", 0, 1, 1, 32'h0, 32'h0000_0400, 0, 0, 64'h0, 64'h0,
             64'hDEAD_BEEF_0000_0400, 10);
        xfer("p1_write", 0, 1, 1, 32'h0, 32'h800, 0, 1, 64'h0,
             64'h1234_5678_9ABC_DEF0, 64'h5555, 3);
        xfer("p0_read", 1, 0, 0, 32'h40, 32'h0, 0, 0, 64'hFFFF, 64'h0, 64'hC0FFEE, 4);

        // Spurious ack in IDLE
        mem_ack_i = 1'b1;
        @(negedge clk);
        check("spur_acks", {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
        check("spur_state", 64'(dut.state_q), 64'(StIdle));
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("spur_state_after", 64'(dut.state_q), 64'(StIdle));
        tick();

        // Ack withheld 20 cycles: timeout_o rises in grant cycle 16, stays up.
        xfer("timeout", 1, 0, 0, 32'h80, 32'h0, 0, 0, 64'h0, 64'h0, 64'h7777, 21);
        @(negedge clk);
        check("timeout_sticky", 64'(timeout_o), 64'd1);
        tick();

        // Reset in the 3rd grant cycle abandons the transfer.
        p1_enable_i = 1'b1; p1_addr_i = 32'hC00; p1_write_i = 1'b0;
        tick();
        p1_enable_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) rst_i = 1'b1;
            @(negedge clk);
            check("rstg_enable", 64'(mem_enable_o), 64'd1);
            check("rstg_acks", {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
            tick();
        end
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        @(negedge clk);
        check("rstg_state", 64'(dut.state_q), 64'(StIdle));
        check("rstg_mem_enable", 64'(mem_enable_o), 64'd0);
        check("rstg_no_ack", {62'd0, p1_ack_o, p0_ack_o}, 64'd0);
        check("rstg_timeout_clr", 64'(timeout_o), 64'd0);
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("rstg_idle_after", 64'(dut.state_q), 64'(StIdle));
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("ack_count", 64'(acks_seen), 64'(acks_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
